// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding Fword/Pword of the DDS core (start -> stop in fixed steps, programmable dwell).
// Optional macro SWEEP_TRIANGLE_EN: continuous mode runs up and back down (triangle) instead of a sawtooth.
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int PW_W    = 12,
  parameter int DWELL_W = 24
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [FW_W-1:0]    cfg_start_fw,
  input  logic [FW_W-1:0]    cfg_stop_fw,
  input  logic [FW_W-1:0]    cfg_step_fw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PW_W-1:0]    cfg_pword,
  input  logic               cfg_cont,
  input  logic               start,
  input  logic               abort,
  output logic [FW_W-1:0]    Fword,
  output logic [PW_W-1:0]    Pword,
  output logic               busy,
  output logic               step_tick,
  output logic               sweep_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [FW_W-1:0]    start_r, stop_r, step_r, fw_nxt;
  logic [DWELL_W-1:0] dwell_r, cnt, cnt_nxt;
  logic [PW_W-1:0]    pw_nxt;
  logic               cont_r, cap, tick_nxt, degen;
`ifdef SWEEP_TRIANGLE_EN
  logic               dir, dir_nxt;
`endif

  // Upward step saturating at lim; sum is one bit wider so it never wraps.
  function automatic logic [FW_W-1:0] sat_up(input logic [FW_W-1:0] f,
                                             input logic [FW_W-1:0] inc,
                                             input logic [FW_W-1:0] lim);
    logic [FW_W:0] sum;
    sum = {1'b0, f} + {1'b0, inc};
    if (inc == '0 || sum >= {1'b0, lim}) sat_up = lim;
    else                                 sat_up = sum[FW_W-1:0];
  endfunction

`ifdef SWEEP_TRIANGLE_EN
  function automatic logic [FW_W-1:0] sat_dn(input logic [FW_W-1:0] f,
                                             input logic [FW_W-1:0] dec,
                                             input logic [FW_W-1:0] lim);
    if (dec == '0 || f <= lim || (f - lim) <= dec) sat_dn = lim;
    else                                           sat_dn = f - dec;
  endfunction
`endif

  // A start word at or above stop collapses the sweep to a single point.
  assign degen = (start_r >= stop_r);

  always_comb begin
    state_nxt = state;
    fw_nxt    = Fword;
    pw_nxt    = Pword;
    cnt_nxt   = cnt;
    tick_nxt  = 1'b0;
    cap       = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
    dir_nxt   = dir;
`endif
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap       = 1'b1;
            fw_nxt    = cfg_start_fw;
            pw_nxt    = cfg_pword;
            cnt_nxt   = cfg_dwell;
            state_nxt = RUN;
`ifdef SWEEP_TRIANGLE_EN
            dir_nxt   = 1'b0;
`endif
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - DWELL_W'(1);
          end else begin
            cnt_nxt  = dwell_r;
            tick_nxt = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
            if (degen) begin
              if (cont_r) fw_nxt = start_r;
              else begin state_nxt = DONE; tick_nxt = 1'b0; end
            end else if (!dir) begin
              if (Fword == stop_r) begin
                if (cont_r) begin
                  dir_nxt = 1'b1;
                  fw_nxt  = sat_dn(stop_r, step_r, start_r);
                end else begin
                  state_nxt = DONE;
                  tick_nxt  = 1'b0;
                end
              end else begin
                fw_nxt = sat_up(Fword, step_r, stop_r);
              end
            end else begin
              if (Fword == start_r) begin
                dir_nxt = 1'b0;
                fw_nxt  = sat_up(start_r, step_r, stop_r);
              end else begin
                fw_nxt  = sat_dn(Fword, step_r, start_r);
              end
            end
`else
            if (Fword == stop_r || degen) begin
              if (cont_r) fw_nxt = start_r;
              else begin state_nxt = DONE; tick_nxt = 1'b0; end
            end else begin
              fw_nxt = sat_up(Fword, step_r, stop_r);
            end
`endif
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      Fword      <= '0;
      Pword      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      step_tick  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      Fword      <= fw_nxt;
      Pword      <= pw_nxt;
      cnt        <= cnt_nxt;
      busy       <= (state_nxt == RUN);
      step_tick  <= tick_nxt;
      sweep_done <= (state_nxt == DONE);
    end
  end

`ifdef SWEEP_TRIANGLE_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) dir <= 1'b0;
    else        dir <= dir_nxt;
  end
`endif

  // Shadow copy of the configuration; only loaded on an accepted start.
  always_ff @(posedge sys_clk) begin
    if (cap) begin
      start_r <= cfg_start_fw;
      stop_r  <= cfg_stop_fw;
      step_r  <= cfg_step_fw;
      dwell_r <= cfg_dwell;
      cont_r  <= cfg_cont;
    end
  end

endmodule
